// File: rtl/spmv_row_accum.sv
// rtl/spmv_row_accum.sv - CSR row dot-product accumulator with a show-ahead result FIFO.
// Optional feature macro: SPMV_ACC_SAT_EN (saturating product/sum and sticky sat_flag).
module spmv_row_accum #(
  parameter int FIFO_DEPTH = 8,
  parameter int ROW_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [ROW_W-1:0] nrows,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      mat_val,
  input  logic [31:0]      vec_val,
  input  logic             row_last,
  input  logic             row_empty,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [ROW_W-1:0] out_row,
  input  logic             out_rd,
  output logic             fifo_full,
  output logic             done,
  output logic             sat_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [ROW_W-1:0] row_idx;
  logic [ROW_W-1:0] nrows_q;
  logic             done_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [ROW_W-1:0] row_mem  [FIFO_DEPTH];

  logic        accept;
  logic        push;
  logic        pop;
  logic        start_acc;
  logic [31:0] beat_sum;
  logic [31:0] push_data;

  assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign in_ready  = (state == RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (row_last || row_empty);
  assign pop       = out_rd && out_valid;
  assign start_acc = start && (state != RUN);
  assign push_data = row_empty ? acc : beat_sum;
  assign done      = done_q;
  // Head is gated so outputs read zero whenever the FIFO is empty, including under reset.
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_row   = out_valid ? row_mem[rd_ptr]  : '0;

`ifdef SPMV_ACC_SAT_EN
  logic [63:0] prod;
  logic [31:0] prod_s;
  logic [32:0] sum;
  logic        beat_sat;
  logic        sat_q;

  assign prod     = {32'b0, mat_val} * {32'b0, vec_val};
  assign prod_s   = (|prod[63:32]) ? 32'hFFFF_FFFF : prod[31:0];
  assign sum      = {1'b0, acc} + {1'b0, prod_s};
  assign beat_sum = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  assign beat_sat = (|prod[63:32]) | sum[32];
  assign sat_flag = sat_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sat_q <= 1'b0;
    end else if (start_acc) begin
      sat_q <= 1'b0;
    end else if (accept && !row_empty && beat_sat) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign beat_sum = acc + mat_val * vec_val;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      acc     <= '0;
      row_idx <= '0;
      nrows_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            acc     <= '0;
            row_idx <= '0;
            nrows_q <= nrows;
            // An empty pass has trivially pushed all of its rows.
            done_q  <= (nrows == '0);
            state   <= (nrows == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (push) begin
              acc     <= '0;
              row_idx <= row_idx + ROW_W'(1);
              if (row_idx == nrows_q - ROW_W'(1)) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end else begin
              acc <= beat_sum;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      row_mem[wr_ptr]  <= row_idx;
    end
  end

endmodule

// File: tb/tb_spmv_row_accum.sv
// tb/tb_spmv_row_accum.sv - randomized self-checking bench for spmv_row_accum against a row-sum model.
module tb_spmv_row_accum;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] nrows = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mat_val = '0;
  logic [31:0] vec_val = '0;
  logic        row_last = 1'b0;
  logic        row_empty = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_row;
  logic        out_rd = 1'b0;
  logic        fifo_full;
  logic        done;
  logic        sat_flag;

  spmv_row_accum #(.FIFO_DEPTH(8), .ROW_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .nrows(nrows),
    .in_valid(in_valid), .in_ready(in_ready), .mat_val(mat_val), .vec_val(vec_val),
    .row_last(row_last), .row_empty(row_empty), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .out_rd(out_rd),
    .fifo_full(fifo_full), .done(done), .sat_flag(sat_flag)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0]     exp_q[$];
  longint unsigned prods[$];
  int              m_row;
  int              m_total;
  bit              m_sat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Dot product of the row's nonzeros under the configured arithmetic rule.
  function automatic logic [31:0] row_result();
    longint unsigned s = 0;
`ifdef SPMV_ACC_SAT_EN
    foreach (prods[i]) begin
      longint unsigned p = prods[i];
      if (p > 64'hFFFF_FFFF) begin p = 64'hFFFF_FFFF; m_sat = 1'b1; end
      s += p;
      if (s > 64'hFFFF_FFFF) begin s = 64'hFFFF_FFFF; m_sat = 1'b1; end
    end
`else
    foreach (prods[i]) s += prods[i];
`endif
    return s[31:0];
  endfunction

  task automatic pop_observe();
    check("pop_model_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      check("pop_data", out_data, exp_q[0][31:0]);
      check("pop_row", out_row, exp_q[0][47:32]);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge Clk);
    start = 1'b1;
    nrows = n[15:0];
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    m_row = 0;
    m_total = n;
    prods.delete();
    m_sat = 1'b0;
    if (n > 0) check("done_clear", done, 0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit last,
                      input bit empty, input int pop_pct);
    bit accepted = 1'b0;
    bit do_pop;
    mat_val = a; vec_val = b; row_last = last; row_empty = empty; in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !accepted; cyc++) begin
      do_pop = out_valid && ($urandom_range(99) < pop_pct);
      if (do_pop) pop_observe();
      out_rd = do_pop;
      accepted = in_ready;
      @(posedge Clk);
      @(negedge Clk);
      out_rd = 1'b0;
      if (do_pop && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    in_valid = 1'b0;
    if (!accepted) begin
      check("accept_timeout", 0, 1);
    end else begin
      if (!empty) prods.push_back(longint'(a) * longint'(b));
      if (empty || last) begin
        exp_q.push_back({m_row[15:0], row_result()});
        prods.delete();
        m_row++;
        if (m_row == m_total) check("done_set", done, 1);
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge Clk);
      check("drain_valid", out_valid, 1);
      pop_observe();
      out_rd = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      out_rd = 1'b0;
      void'(exp_q.pop_front());
      guard++;
    end
    check("drain_empty", out_valid, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    int n, len;

    repeat (3) @(negedge Clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    Rst = 1'b1;
    @(negedge Clk);
    check("idle_in_ready", in_ready, 0);

    // Two-row example with known products.
    do_start(2);
    send(91, 46, 1, 0, 0);
    send(37, 51, 0, 0, 0);
    send(69, 5, 0, 0, 0);
    send(100, 87, 1, 0, 0);
    check("ex_head_data", out_data, 4186);
    check("ex_head_row", out_row, 0);
    drain();

    // Empty middle row, with row_last also set to exercise precedence.
    do_start(3);
    send(2, 3, 1, 0, 0);
    send(32'hDEAD, 32'hBEEF, 1, 1, 0);
    send(4, 5, 1, 0, 0);
    drain();

    do_start(0);
    check("nrows0_in_ready", in_ready, 0);

    // Fill the FIFO, stall the ninth row, then release with pops.
    do_start(9);
    for (int i = 0; i < 8; i++) send(i + 1, 2, 1, 0, 0);
    check("full_flag", fifo_full, 1);
    check("full_in_ready", in_ready, 0);
    mat_val = 9; vec_val = 2; row_last = 1'b1; row_empty = 1'b0; in_valid = 1'b1;
    repeat (3) @(negedge Clk);
    check("stall_full", fifo_full, 1);
    check("stall_head_row", out_row, 0);
    send(9, 2, 1, 0, 100);
    drain();

    // Three buffered entries, then a push concurrent with a pop.
    do_start(4);
    for (int i = 0; i < 3; i++) send(i + 10, 3, 1, 0, 0);
    send(20, 3, 1, 0, 100);
    check("concurrent_full", fifo_full, 0);
    drain();

    // Reset in the middle of a row with one result still buffered.
    do_start(2);
    send(5, 6, 1, 0, 0);
    send(7, 8, 0, 0, 0);
    send(9, 9, 0, 0, 0);
    Rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_row", out_row, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_sat", sat_flag, 0);
    exp_q.delete();
    prods.delete();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("postrst_in_ready", in_ready, 0);
    do_start(1);
    send(3, 4, 1, 0, 0);
    check("postrst_data", out_data, 12);
    drain();

    // Product overflow case.
    do_start(1);
    send(32'hFFFF_0000, 32'h0002_0000, 1, 0, 0);
`ifdef SPMV_ACC_SAT_EN
    check("ovf_data", out_data, 32'hFFFF_FFFF);
    check("ovf_sat", sat_flag, 1);
`else
    check("ovf_data", out_data, 32'h0000_0000);
    check("ovf_sat", sat_flag, 0);
`endif
    drain();

    // Random passes against the model.
    for (int pass = 0; pass < 20; pass++) begin
      n = $urandom_range(1, 5);
      do_start(n);
      for (int r = 0; r < n; r++) begin
        len = $urandom_range(0, 3);
        if (len == 0) begin
          send($urandom, $urandom, $urandom_range(1), 1, 50);
        end else begin
          for (int k = 0; k < len; k++) begin
            a = $urandom_range(1) ? $urandom : $urandom_range(1000);
            b = $urandom_range(1) ? $urandom : $urandom_range(1000);
            send(a, b, k == len - 1, 0, 50);
          end
        end
      end
      check("rand_sat", sat_flag, m_sat);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
